// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - raster timing generator with selectable test patterns (optional border: PATTERN_BORDER_EN)
module video_pattern_gen #(
  parameter int H_TOTAL  = 1650,
  parameter int H_SYNC   = 40,
  parameter int H_BPORCH = 220,
  parameter int H_RES    = 1280,
  parameter int V_TOTAL  = 750,
  parameter int V_SYNC   = 5,
  parameter int V_BPORCH = 20,
  parameter int V_RES    = 720,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int DATA_W   = 8
) (
  input  logic              I_pxl_clk,
  input  logic              I_rst,
  input  logic [1:0]        I_mode,
  output logic              O_de,
  output logic              O_hs,
  output logic              O_vs,
  output logic [DATA_W-1:0] O_data_r,
  output logic [DATA_W-1:0] O_data_g,
  output logic [DATA_W-1:0] O_data_b,
  output logic [15:0]       O_frame_cnt,
  output logic              O_fps_toggle
);

  localparam int HW    = $clog2(H_TOTAL);
  localparam int VW    = $clog2(V_TOTAL);
  localparam int H_ACT = H_SYNC + H_BPORCH;
  localparam int V_ACT = V_SYNC + V_BPORCH;
  localparam int BAR_W = H_RES / 8;
  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);
  localparam logic [DATA_W-1:0] FULL = {DATA_W{1'b1}};

  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [1:0]        mode_q;
  logic [1:0]        mode_eff;
  logic              h_last;
  logic              v_last;
  logic [31:0]       x_w;
  logic [31:0]       y_w;
  logic [2:0]        bar;
  logic              de_c;
  logic              hs_c;
  logic              vs_c;
  logic [DATA_W-1:0] r_c;
  logic [DATA_W-1:0] g_c;
  logic [DATA_W-1:0] b_c;

  // Counter decode, active coordinates and pattern colour for the current raster position
  always_comb begin
    h_last   = (32'(h_cnt) == 32'(H_TOTAL - 1));
    v_last   = (32'(v_cnt) == 32'(V_TOTAL - 1));
    // The mode is picked up at the frame origin so a whole frame always uses one pattern
    mode_eff = ((h_cnt == '0) && (v_cnt == '0)) ? I_mode : mode_q;
    // Unsigned wrap makes positions before the active window huge, so one compare per axis suffices
    x_w      = 32'(h_cnt) - 32'(H_ACT);
    y_w      = 32'(v_cnt) - 32'(V_ACT);
    de_c     = (x_w < 32'(H_RES)) && (y_w < 32'(V_RES));
    hs_c     = (32'(h_cnt) < 32'(H_SYNC)) ? HS_ACT : ~HS_ACT;
    vs_c     = (32'(v_cnt) < 32'(V_SYNC)) ? VS_ACT : ~VS_ACT;
    bar      = 3'(x_w / 32'(BAR_W));
    r_c      = '0;
    g_c      = '0;
    b_c      = '0;
    case (mode_eff)
      2'd0: begin
        // Bar order white,yellow,cyan,green,magenta,red,blue,black reduces to inverted index bits
        r_c = {DATA_W{~bar[1]}};
        g_c = {DATA_W{~bar[2]}};
        b_c = {DATA_W{~bar[0]}};
      end
      2'd1: begin
        r_c = DATA_W'(x_w);
        g_c = DATA_W'(x_w);
        b_c = DATA_W'(x_w);
      end
      2'd2: begin
        if (x_w[5] ^ y_w[5]) begin
          r_c = FULL;
          g_c = FULL;
          b_c = FULL;
        end
      end
      default: begin
        r_c = DATA_W'(x_w + 32'(O_frame_cnt));
        g_c = DATA_W'(y_w);
        b_c = '0;
      end
    endcase
`ifdef PATTERN_BORDER_EN
    if ((x_w == 32'd0) || (x_w == 32'(H_RES - 1)) || (y_w == 32'd0) || (y_w == 32'(V_RES - 1))) begin
      r_c = FULL;
      g_c = FULL;
      b_c = FULL;
    end
`endif
  end

  // Raster counters and per-frame mode latch
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      mode_q <= 2'd0;
    end else begin
      mode_q <= mode_eff;
      if (h_last) begin
        h_cnt <= '0;
        if (v_last) v_cnt <= '0;
        else        v_cnt <= v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Frame counter and scope toggle, stepped on the last pixel of the frame
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      O_frame_cnt  <= 16'd0;
      O_fps_toggle <= 1'b0;
    end else if (h_last && v_last) begin
      O_frame_cnt  <= O_frame_cnt + 16'd1;
      O_fps_toggle <= ~O_fps_toggle;
    end
  end

  // Registered video outputs, all one cycle behind the counters
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      O_de     <= 1'b0;
      O_hs     <= ~HS_ACT;
      O_vs     <= ~VS_ACT;
      O_data_r <= '0;
      O_data_g <= '0;
      O_data_b <= '0;
    end else begin
      O_de     <= de_c;
      O_hs     <= hs_c;
      O_vs     <= vs_c;
      O_data_r <= de_c ? r_c : '0;
      O_data_g <= de_c ? g_c : '0;
      O_data_b <= de_c ? b_c : '0;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb/tb_video_pattern_gen.sv - scoreboard bench for video_pattern_gen on a small raster
module tb_video_pattern_gen;

  typedef logic [43:0] vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;

  logic        de, hs, vs, fps;
  logic [7:0]  dr, dg, db;
  logic [15:0] frame;
  logic        n_de, n_hs, n_vs, n_fps;
  logic [7:0]  n_dr, n_dg, n_db;
  logic [15:0] n_frame;

  vec_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  int          m_h = 0;
  int          m_v = 0;
  logic [1:0]  m_mode = 2'd0;
  logic [15:0] m_frame = 16'd0;
  logic        m_fps = 1'b0;

  int rel_cyc = 0;
  int first_de = -1;
  int hs_run = 0;
  int vs_run = 0;
  int hs_w = 0;
  int vs_w = 0;

  logic [23:0] bar_tbl [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  video_pattern_gen #(
    .H_TOTAL(20), .H_SYNC(2), .H_BPORCH(3), .H_RES(8),
    .V_TOTAL(10), .V_SYNC(1), .V_BPORCH(2), .V_RES(4),
    .HS_POL(1), .VS_POL(1), .DATA_W(8)
  ) dut (
    .I_pxl_clk(clk), .I_rst(rst), .I_mode(mode),
    .O_de(de), .O_hs(hs), .O_vs(vs),
    .O_data_r(dr), .O_data_g(dg), .O_data_b(db),
    .O_frame_cnt(frame), .O_fps_toggle(fps)
  );

  video_pattern_gen #(
    .H_TOTAL(20), .H_SYNC(2), .H_BPORCH(3), .H_RES(8),
    .V_TOTAL(10), .V_SYNC(1), .V_BPORCH(2), .V_RES(4),
    .HS_POL(0), .VS_POL(0), .DATA_W(8)
  ) dut_n (
    .I_pxl_clk(clk), .I_rst(rst), .I_mode(mode),
    .O_de(n_de), .O_hs(n_hs), .O_vs(n_vs),
    .O_data_r(n_dr), .O_data_g(n_dg), .O_data_b(n_db),
    .O_frame_cnt(n_frame), .O_fps_toggle(n_fps)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pix(logic [1:0] md, int x, int y, logic [15:0] fr);
    logic [23:0] p;
    case (md)
      2'd0:    p = bar_tbl[x];
      2'd1:    p = {3{8'(x)}};
      2'd2:    p = (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
      default: p = {8'(x + int'(fr)), 8'(y), 8'h00};
    endcase
`ifdef PATTERN_BORDER_EN
    if (x == 0 || x == 7 || y == 0 || y == 3) p = 24'hFFFFFF;
`endif
    return p;
  endfunction

  task automatic check(string tag, int got, int exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    vec_t        e;
    vec_t        obs;
    vec_t        obs_n;
    logic        de_e, hs_e, vs_e;
    logic [23:0] rgb;
    if (rst) begin
      e = '0;
      m_h = 0; m_v = 0; m_mode = 2'd0; m_frame = 16'd0; m_fps = 1'b0;
    end else begin
      if (m_h == 0 && m_v == 0) m_mode = mode;
      de_e = (m_h >= 5 && m_h < 13 && m_v >= 3 && m_v < 7);
      hs_e = (m_h < 2);
      vs_e = (m_v < 1);
      rgb  = de_e ? pix(m_mode, m_h - 5, m_v - 3, m_frame) : 24'h0;
      if (m_h == 19 && m_v == 9) begin
        m_frame = m_frame + 16'd1;
        m_fps   = ~m_fps;
      end
      if (m_h == 19) begin
        m_h = 0;
        m_v = (m_v == 9) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
      e = {de_e, hs_e, vs_e, rgb, m_frame, m_fps};
    end
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    e     = sb_q.pop_front();
    obs   = {de, hs, vs, dr, dg, db, frame, fps};
    obs_n = {n_de, n_hs, n_vs, n_dr, n_dg, n_db, n_frame, n_fps};
    n_vec++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL out_pos cyc=%0d got=%h exp=%h", cyc, obs, e);
    end
    n_vec++;
    assert (obs_n === (e ^ 44'h600_0000_0000)) else begin
      n_err++;
      $error("FAIL out_neg cyc=%0d got=%h exp=%h", cyc, obs_n, e ^ 44'h600_0000_0000);
    end
    if (rst) begin
      rel_cyc  = 0;
      first_de = -1;
    end else begin
      rel_cyc++;
      if (first_de < 0 && de) first_de = rel_cyc;
    end
    if (hs) hs_run++;
    else begin
      if (hs_run > 0) hs_w = hs_run;
      hs_run = 0;
    end
    if (vs) vs_run++;
    else begin
      if (vs_run > 0) vs_w = vs_run;
      vs_run = 0;
    end
  endtask

  initial begin
    rst  = 1'b1;
    mode = 2'd0;
    repeat (3) step();
    check("rst_de", int'(de), 0);
    check("rst_frame", int'(frame), 0);

    rst = 1'b0;
    repeat (600) step();
    check("first_de", first_de, 66);
    check("hs_width", hs_w, 2);
    check("vs_width", vs_w, 20);
    check("frame_cnt_3", int'(frame), 3);
    check("fps_toggle", int'(fps), 1);

    mode = 2'd1;
    repeat (200) step();
    mode = 2'd3;
    repeat (400) step();

    mode = 2'd0;
    repeat (90) step();
    mode = 2'd2;
    repeat (310) step();

    repeat (100) step();
    rst = 1'b1;
    step();
    check("midrst_de", int'(de), 0);
    check("midrst_hs", int'(hs), 0);
    check("midrst_frame", int'(frame), 0);
    check("midrst_fps", int'(fps), 0);
    rst = 1'b0;
    repeat (250) step();
    check("first_de_after_rst", first_de, 66);
    check("frame_after_rst", int'(frame), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
